// File: rtl/game_sequencer_pkg.sv
// Shared chess-clock definitions: game-flow states, flag-fall result codes, turn encoding.
package chess_clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FLAG  = 2'd3
    } state_t;

    localparam logic [1:0] LOSER_NONE = 2'b00;
    localparam logic [1:0] LOSER_P1   = 2'b01;
    localparam logic [1:0] LOSER_P2   = 2'b10;

    localparam logic TURN_P1 = 1'b0;
    localparam logic TURN_P2 = 1'b1;

endpackage

// File: rtl/game_sequencer_if.sv
// Button/flag inputs and switch/counter controls between the front-end and the game sequencer.
interface game_sequencer_if #(
    parameter int PRESET_W = 2,
    parameter int MOVE_W   = 8
);
    logic                BTN_P1;
    logic                BTN_P2;
    logic                BTN_START;
    logic                BTN_MODE;
    logic                ZERO_P1;
    logic                ZERO_P2;
    logic                SELECT;
    logic                STOP;
    logic                END;
    logic                LOAD;
    logic [PRESET_W-1:0] PRESET;
    logic                ADD_P1;
    logic                ADD_P2;
    logic [1:0]          LOSER;
    logic [MOVE_W-1:0]   MOVES;

    modport master (
        output BTN_P1, BTN_P2, BTN_START, BTN_MODE, ZERO_P1, ZERO_P2,
        input  SELECT, STOP, END, LOAD, PRESET, ADD_P1, ADD_P2, LOSER, MOVES
    );

    modport slave (
        input  BTN_P1, BTN_P2, BTN_START, BTN_MODE, ZERO_P1, ZERO_P2,
        output SELECT, STOP, END, LOAD, PRESET, ADD_P1, ADD_P2, LOSER, MOVES
    );
endinterface

// File: rtl/game_sequencer.sv
// Chess-clock game-flow controller: IDLE/RUN/PAUSE/FLAG sequencing, preset select,
// increment pulses, full-move count and flag-fall result, all registered.
module game_sequencer
    import chess_clock_pkg::*;
#(
    parameter int PRESET_W = 2,
    parameter int MOVE_W   = 8,
    parameter int INC_EN   = 1
) (
    input  logic                CLK,
    input  logic                CLR,
    game_sequencer_if.slave     bus
);

    localparam logic INC_ON = (INC_EN != 0);

    state_t              state;
    logic                select;
    logic                stop;
    logic                game_end;
    logic                load;
    logic [PRESET_W-1:0] preset;
    logic                add_p1;
    logic                add_p2;
    logic [1:0]          loser;
    logic [MOVE_W-1:0]   moves;

    logic active_zero;
    logic active_press;

    always_comb begin
        active_zero  = (select == TURN_P1) ? bus.ZERO_P1 : bus.ZERO_P2;
        active_press = (select == TURN_P1) ? bus.BTN_P1  : bus.BTN_P2;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            select   <= TURN_P1;
            stop     <= 1'b1;
            game_end <= 1'b0;
            load     <= 1'b0;
            preset   <= '0;
            add_p1   <= 1'b0;
            add_p2   <= 1'b0;
            loser    <= LOSER_NONE;
            moves    <= '0;
        end else begin
            load   <= 1'b0;
            add_p1 <= 1'b0;
            add_p2 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.BTN_START) begin
                        state  <= RUN;
                        load   <= 1'b1;
                        select <= TURN_P1;
                        stop   <= 1'b0;
                        moves  <= '0;
                        loser  <= LOSER_NONE;
                    end else if (bus.BTN_MODE) begin
                        preset <= preset + 1'b1;
                    end
                end
                RUN: begin
                    // Flag beats START, START beats a clock hit in the same cycle.
                    if (active_zero) begin
                        state    <= FLAG;
                        stop     <= 1'b1;
                        game_end <= 1'b1;
                        loser    <= (select == TURN_P1) ? LOSER_P1 : LOSER_P2;
                    end else if (bus.BTN_START) begin
                        state <= PAUSE;
                        stop  <= 1'b1;
                    end else if (active_press) begin
                        if (select == TURN_P1) begin
                            select <= TURN_P2;
                            add_p1 <= INC_ON;
                        end else begin
                            select <= TURN_P1;
                            add_p2 <= INC_ON;
                            if (moves != '1) begin
                                moves <= moves + 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.BTN_START) begin
                        state <= RUN;
                        stop  <= 1'b0;
                    end
                end
                FLAG: begin
                    if (bus.BTN_START) begin
                        state    <= IDLE;
                        game_end <= 1'b0;
                        loser    <= LOSER_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SELECT = select;
    assign bus.STOP   = stop;
    assign bus.END    = game_end;
    assign bus.LOAD   = load;
    assign bus.PRESET = preset;
    assign bus.ADD_P1 = add_p1;
    assign bus.ADD_P2 = add_p2;
    assign bus.LOSER  = loser;
    assign bus.MOVES  = moves;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed table-driven bench for game_sequencer: default build plus a MOVE_W=2, INC_EN=0 build.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    game_sequencer_if #(.PRESET_W(2), .MOVE_W(8)) bus_a ();
    game_sequencer_if #(.PRESET_W(2), .MOVE_W(2)) bus_b ();

    game_sequencer #(.PRESET_W(2), .MOVE_W(8), .INC_EN(1)) dut_a (
        .CLK(clk), .CLR(clr), .bus(bus_a)
    );
    game_sequencer #(.PRESET_W(2), .MOVE_W(2), .INC_EN(0)) dut_b (
        .CLK(clk), .CLR(clr), .bus(bus_b)
    );

    // input vector bits: {P1, P2, START, MODE, Z1, Z2}
    localparam logic [5:0] I_NO = 6'b000000;
    localparam logic [5:0] I_P1 = 6'b100000;
    localparam logic [5:0] I_P2 = 6'b010000;
    localparam logic [5:0] I_ST = 6'b001000;
    localparam logic [5:0] I_MD = 6'b000100;
    localparam logic [5:0] I_Z1 = 6'b000010;
    localparam logic [5:0] I_Z2 = 6'b000001;

    typedef struct {
        logic [5:0]  in;
        logic [17:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [17:0] e(input logic sel, input logic stp, input logic en,
                                      input logic ld, input logic a1, input logic a2,
                                      input logic [1:0] los, input logic [1:0] pre,
                                      input logic [7:0] mv);
        return {sel, stp, en, ld, a1, a2, los, pre, mv};
    endfunction

    function automatic logic [17:0] pack_a();
        return {bus_a.SELECT, bus_a.STOP, bus_a.END, bus_a.LOAD, bus_a.ADD_P1,
                bus_a.ADD_P2, bus_a.LOSER, bus_a.PRESET, bus_a.MOVES};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic [5:0] in);
        {bus_a.BTN_P1, bus_a.BTN_P2, bus_a.BTN_START, bus_a.BTN_MODE,
         bus_a.ZERO_P1, bus_a.ZERO_P2} = in;
    endtask

    task automatic drive_b(input logic [5:0] in);
        {bus_b.BTN_P1, bus_b.BTN_P2, bus_b.BTN_START, bus_b.BTN_MODE,
         bus_b.ZERO_P1, bus_b.ZERO_P2} = in;
    endtask

    // Present inputs for one active edge, then sample just after it.
    task automatic step(input logic [5:0] in_a, input logic [5:0] in_b, input logic c);
        drive_a(in_a);
        drive_b(in_b);
        clr = c;
        @(posedge clk);
        #1;
        drive_a(I_NO);
        drive_b(I_NO);
        clr = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        drive_a(I_NO);
        drive_b(I_NO);

        vt.push_back('{I_MD,           e(0,1,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_MD,           e(0,1,0,0,0,0,2'b00,2'd2,8'd0)});
        vt.push_back('{I_MD,           e(0,1,0,0,0,0,2'b00,2'd3,8'd0)});
        vt.push_back('{I_MD,           e(0,1,0,0,0,0,2'b00,2'd0,8'd0)});
        vt.push_back('{I_MD,           e(0,1,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_ST|I_MD,      e(0,0,0,1,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_NO,           e(0,0,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_P2,           e(0,0,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_P1,           e(1,0,0,0,1,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_NO,           e(1,0,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_P2,           e(0,0,0,0,0,1,2'b00,2'd1,8'd1)});
        vt.push_back('{I_P1|I_P2,      e(1,0,0,0,1,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_Z1,           e(1,0,0,0,0,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_MD,           e(1,0,0,0,0,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_ST,           e(1,1,0,0,0,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_P2|I_Z2,      e(1,1,0,0,0,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_ST,           e(1,0,0,0,0,0,2'b00,2'd1,8'd1)});
        vt.push_back('{I_P2,           e(0,0,0,0,0,1,2'b00,2'd1,8'd2)});
        vt.push_back('{I_Z1|I_P1,      e(0,1,1,0,0,0,2'b01,2'd1,8'd2)});
        vt.push_back('{I_ST|I_MD|I_P1, e(0,1,0,0,0,0,2'b00,2'd1,8'd2)});
        vt.push_back('{I_ST,           e(0,0,0,1,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_P1,           e(1,0,0,0,1,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_Z2|I_ST,      e(1,1,1,0,0,0,2'b10,2'd1,8'd0)});
        vt.push_back('{I_ST,           e(1,1,0,0,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_ST,           e(0,0,0,1,0,0,2'b00,2'd1,8'd0)});
        vt.push_back('{I_P1,           e(1,0,0,0,1,0,2'b00,2'd1,8'd0)});

        @(negedge clk);
        step(I_NO, I_NO, 1'b1);
        step(I_NO, I_NO, 1'b1);
        chk("reset_a", 32'(pack_a()), 32'(e(0,1,0,0,0,0,2'b00,2'd0,8'd0)));
        chk("reset_b", {28'd0, bus_b.STOP, bus_b.LOAD, bus_b.MOVES}, {28'd0, 1'b1, 1'b0, 2'd0});

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].in, I_NO, 1'b0);
            chk($sformatf("vec[%0d]", i), 32'(pack_a()), 32'(vt[i].exp));
        end

        // Mid-game reset with a clock hit present: no ADD, everything back to reset values.
        step(I_P2, I_NO, 1'b1);
        chk("clr_midgame", 32'(pack_a()), 32'(e(0,1,0,0,0,0,2'b00,2'd0,8'd0)));
        step(I_P1, I_NO, 1'b0);
        chk("clr_idle_p1", 32'(pack_a()), 32'(e(0,1,0,0,0,0,2'b00,2'd0,8'd0)));
        step(I_ST, I_NO, 1'b0);
        chk("clr_restart", 32'(pack_a()), 32'(e(0,0,0,1,0,0,2'b00,2'd0,8'd0)));

        // MOVE_W=2, INC_EN=0 build: saturation at 3 and no increment pulses.
        step(I_NO, I_ST, 1'b0);
        chk("b_load", {31'd0, bus_b.LOAD}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step(I_NO, I_P1, 1'b0);
            chk($sformatf("b_p1_sel[%0d]", k), {30'd0, bus_b.SELECT, bus_b.ADD_P1}, {30'd0, 1'b1, 1'b0});
            step(I_NO, I_P2, 1'b0);
            chk($sformatf("b_p2_moves[%0d]", k), {29'd0, bus_b.ADD_P2, bus_b.MOVES},
                {29'd0, 1'b0, (k > 3) ? 2'd3 : 2'(k)});
        end
        chk("b_stop", {30'd0, bus_b.STOP, bus_b.END}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the chess clock. It turns debounced player and panel button pulses plus the two players' time-zero flags into the SELECT/STOP/END controls for the player-enable switch. It also drives preset loading and Fischer-increment pulses to the player time counters, and keeps the full-move count and the flag-fall result. It sits between the button front-end and the switch/counter datapath.

Parameters:
PRESET_W, 2, width of time-control preset index (2**PRESET_W presets)
MOVE_W, 8, width of full-move counter
INC_EN, 1, 1 = emit ADD_Px increment pulses on move completion; 0 = never pulse

Ports:
CLK  in  1  system clock
CLR  in  1  reset, synchronous, active-high
BTN_P1  in  1  single-cycle pulse: player 1 hits clock
BTN_P2  in  1  single-cycle pulse: player 2 hits clock
BTN_START  in  1  single-cycle pulse: start / pause / resume / acknowledge
BTN_MODE  in  1  single-cycle pulse: step time-control preset
ZERO_P1  in  1  level: player 1 remaining time == 0
ZERO_P2  in  1  level: player 2 remaining time == 0
SELECT  out  1  0 = player 1 clock runs, 1 = player 2 clock runs
STOP  out  1  1 = both clocks halted (idle/pause/flag)
END  out  1  1 = game over (flag fallen)
LOAD  out  1  one-cycle pulse: counters load preset time
PRESET  out  PRESET_W  selected time-control preset
ADD_P1  out  1  one-cycle pulse: add increment to player 1
ADD_P2  out  1  one-cycle pulse: add increment to player 2
LOSER  out  2  00 none, 01 player 1 flagged, 10 player 2 flagged, 11 unused
MOVES  out  MOVE_W  completed full moves, saturating

Behaviour:
- Single clock domain (CLK). Reset is synchronous and active-high on CLR and has priority over everything.
- All outputs are registered. An input sampled at edge N produces the response at edge N (visible cycle N+1).
- Reset values: state IDLE, SELECT 0, STOP 1, END 0, LOAD 0, PRESET 0, ADD_P1 0, ADD_P2 0, LOSER 00, MOVES 0.
- States: IDLE, RUN, PAUSE, FLAG.
- IDLE (STOP=1, END=0):
  - BTN_MODE: PRESET+1, wraps from all-ones to 0.
  - BTN_START: go to RUN; LOAD=1 for exactly one cycle; SELECT=0; STOP=0; MOVES=0; LOSER=00.
  - BTN_START and BTN_MODE in the same cycle: start wins; PRESET unchanged.
  - BTN_Px and ZERO_Px are ignored.
- RUN (STOP=0). Priority order: flag > START > player button.
  - ZERO of the active player (P1 if SELECT=0, else P2): go to FLAG; END=1; STOP=1; LOSER=01 or 10; SELECT held.
  - BTN_START: go to PAUSE; STOP=1; SELECT held.
  - BTN_P1 with SELECT=0: SELECT becomes 1; ADD_P1 pulses one cycle if INC_EN.
  - BTN_P2 with SELECT=1: SELECT becomes 0; ADD_P2 pulses one cycle if INC_EN; MOVES+1, saturating at 2**MOVE_W-1.
  - Button of the inactive player: ignored.
  - Both player buttons in one cycle: only the active player's press is taken.
  - ZERO of the inactive player: ignored.
  - BTN_MODE: ignored.
- PAUSE (STOP=1, END=0):
  - BTN_START: go to RUN; STOP=0; same SELECT as before pausing.
  - All other inputs, including ZERO, are ignored. No LOAD pulse.
- FLAG (STOP=1, END=1):
  - BTN_START: go to IDLE; END=0; LOSER=00; MOVES holds until the next start; PRESET kept.
  - All other inputs are ignored.
- ADD_Px and LOAD are never asserted for two consecutive cycles. ADD_Px is never asserted in the same cycle as a FLAG transition.
- CLR in mid-game: returns to reset values on the next edge. No LOAD or ADD pulse is issued.

Decomposition:
- Shared package chess_clock_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, FLAG);
  - the LOSER codes (LOSER_NONE=2'b00, LOSER_P1=2'b01, LOSER_P2=2'b10);
  - the turn encoding constants TURN_P1=1'b0, TURN_P2=1'b1 for SELECT.
- One flat module; no sub-module. The saturating move counter is inline.

Test Plan:
- Reset, then three BTN_MODE pulses in IDLE -> PRESET 0,1,2,3; a fourth pulse -> PRESET 0 (wrap); STOP=1, END=0 throughout.
- IDLE then BTN_START -> next cycle LOAD=1 for exactly one cycle, STOP=0, SELECT=0. BTN_P2 while SELECT=0 -> no change. BTN_P1 -> SELECT=1, ADD_P1 one-cycle pulse. BTN_P2 -> SELECT=0, ADD_P2 pulse, MOVES=1.
- In RUN with SELECT=1, BTN_START -> STOP=1, SELECT=1. BTN_P2 and ZERO_P2 while paused -> ignored. BTN_START -> STOP=0, SELECT=1, no LOAD.
- In RUN with SELECT=0, ZERO_P1 and BTN_P1 in the same cycle -> FLAG: END=1, STOP=1, LOSER=01, SELECT=0, no ADD_P1. BTN_START -> IDLE, END=0, LOSER=00.
- With MOVE_W=2, complete 5 full moves -> MOVES saturates at 3. With INC_EN=0, no ADD pulses occur.
- CLR asserted in RUN mid-game -> next cycle all outputs at reset values, state IDLE, PRESET=0.
